// File: rtl/eth_phy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_phy_pkg
// Description : Shared constants and receive state encoding for the PHY
//               receive deframer: preamble and SFD patterns for MII nibble
//               and GMII byte units, plus the deframer state type.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_phy_pkg;

  localparam logic [3:0] PRE_NIB  = 4'h5;
  localparam logic [3:0] SFD_NIB  = 4'hD;
  localparam logic [7:0] PRE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } rx_state_t;

endpackage : eth_phy_pkg
`default_nettype wire

// File: rtl/phy_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : phy_rx_fifo
// Description : Synchronous first-word fall-through FIFO. The head entry is
//               visible on o_rd_data whenever o_empty is low; the read data
//               is forced to zero while empty so nothing stale leaks out.
//               A write is accepted when full if a read happens on the same
//               edge.
// Ports       : clk, rst_n          - clock, async active-low reset
//               i_wr_en, i_wr_data  - write request and data
//               i_rd_en             - pop head entry (ignored when empty)
//               o_rd_data           - head entry
//               o_full, o_empty     - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module phy_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_rd;
  logic             w_wr;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_rd = i_rd_en && !o_empty;
  assign w_wr = i_wr_en && (!o_full || w_rd);

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule : phy_rx_fifo
`default_nettype wire

// File: rtl/phy_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module      : phy_rx_deframer
// Description : Receive-side MII/GMII deframer. Registers the PHY pins,
//               strips preamble/SFD, packs payload bytes into BYTES-wide
//               words and delivers them through a FWFT FIFO on a ready/valid
//               stream with sop/eop/keep/err sideband. Keeps saturating
//               ok/err/drop frame counters.
// Ports       : mrx_clk_pad_i, mrx_rst_n_i         - clock, async reset
//               mrxd_pad_i, mrxdv_pad_i, mrxerr_pad_i - PHY receive pins
//               rx_data_o, rx_keep_o, rx_sop_o, rx_eop_o, rx_err_o,
//               rx_valid_o, rx_ready_i            - output word stream
//               stat_ok_o, stat_err_o, stat_drop_o  - frame statistics
// Revision    : 1.0 - initial release
// ============================================================================
module phy_rx_deframer
  import eth_phy_pkg::*;
#(
  parameter int PHY_W = 4,
  parameter int BYTES = 4,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic               mrx_clk_pad_i,
  input  logic               mrx_rst_n_i,
  input  logic [PHY_W-1:0]   mrxd_pad_i,
  input  logic               mrxdv_pad_i,
  input  logic               mrxerr_pad_i,
  output logic [8*BYTES-1:0] rx_data_o,
  output logic [BYTES-1:0]   rx_keep_o,
  output logic               rx_sop_o,
  output logic               rx_eop_o,
  output logic               rx_err_o,
  output logic               rx_valid_o,
  input  logic               rx_ready_i,
  output logic [CNT_W-1:0]   stat_ok_o,
  output logic [CNT_W-1:0]   stat_err_o,
  output logic [CNT_W-1:0]   stat_drop_o
);

  localparam int WW = 8 * BYTES;
  localparam int FW = WW + BYTES + 3;
  localparam int CW = $clog2(BYTES + 1);

  logic [PHY_W-1:0] r_rxd;
  logic             r_dv;
  logic             r_er;

  rx_state_t        r_state, w_state_nxt;
  logic [WW-1:0]    r_acc, w_acc_nxt, w_merge;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_sop_pend, w_sop_nxt;
  logic             r_err, w_err_nxt;
  logic             r_abort, w_abort_nxt;
  logic [CNT_W-1:0] r_stat_ok, r_stat_err, r_stat_drop;

  logic [7:0]       w_byte;
  logic             w_byte_done, w_is_pre, w_is_sfd, w_dribble;
  logic [BYTES-1:0] w_keep_part;
  logic             w_req, w_push, w_space, w_ovf, w_full, w_empty, w_pop;
  logic [WW-1:0]    w_pdata;
  logic [BYTES-1:0] w_pkeep;
  logic             w_psop, w_peop, w_perr;
  logic             w_inc_ok, w_inc_err, w_inc_drop;
  logic [FW-1:0]    w_rd_data;

  always_ff @(posedge mrx_clk_pad_i or negedge mrx_rst_n_i) begin
    if (!mrx_rst_n_i) begin
      r_rxd <= '0;
      r_dv  <= 1'b0;
      r_er  <= 1'b0;
    end else begin
      r_rxd <= mrxd_pad_i;
      r_dv  <= mrxdv_pad_i;
      r_er  <= mrxerr_pad_i;
    end
  end

  // Unit decode. In MII the first nibble of each byte is parked until its
  // partner arrives; the parking register only runs while in DATA.
  if (PHY_W == 4) begin : g_mii
    logic [3:0] r_nib;
    logic       r_nib_have;

    always_ff @(posedge mrx_clk_pad_i or negedge mrx_rst_n_i) begin
      if (!mrx_rst_n_i) begin
        r_nib      <= '0;
        r_nib_have <= 1'b0;
      end else if (r_state == DATA && r_dv) begin
        r_nib_have <= !r_nib_have;
        if (!r_nib_have) r_nib <= r_rxd;
      end else begin
        r_nib_have <= 1'b0;
      end
    end

    assign w_is_pre    = (r_rxd == PRE_NIB);
    assign w_is_sfd    = (r_rxd == SFD_NIB);
    assign w_byte      = {r_rxd, r_nib};
    assign w_byte_done = r_dv && r_nib_have;
    assign w_dribble   = r_nib_have;
  end else begin : g_gmii
    assign w_is_pre    = (r_rxd == PRE_BYTE);
    assign w_is_sfd    = (r_rxd == SFD_BYTE);
    assign w_byte      = r_rxd;
    assign w_byte_done = r_dv;
    assign w_dribble   = 1'b0;
  end

  always_comb begin
    w_merge     = r_acc;
    w_keep_part = '0;
    for (int k = 0; k < BYTES; k++) begin
      if (CW'(k) == r_cnt) w_merge[8*k +: 8] = w_byte;
      w_keep_part[k] = (CW'(k) < r_cnt);
    end
  end

  assign w_pop   = rx_valid_o && rx_ready_i;
  assign w_space = !w_full || w_pop;
  assign w_push  = w_req && w_space;

  // A full word is held until the next cycle so that, when the frame ends
  // exactly on a word boundary, the word itself carries eop.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_sop_nxt   = r_sop_pend;
    w_err_nxt   = r_err;
    w_abort_nxt = r_abort;
    w_req       = 1'b0;
    w_pdata     = '0;
    w_pkeep     = '0;
    w_psop      = 1'b0;
    w_peop      = 1'b0;
    w_perr      = 1'b0;
    w_ovf       = 1'b0;
    w_inc_ok    = 1'b0;
    w_inc_err   = 1'b0;
    w_inc_drop  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_dv) begin
          if (w_is_pre) begin
            w_state_nxt = PRE;
          end else begin
            w_state_nxt = DROP;
            w_inc_drop  = 1'b1;
          end
        end
      end
      PRE: begin
        if (!r_dv || !(w_is_pre || w_is_sfd)) begin
          w_state_nxt = DROP;
          w_inc_drop  = 1'b1;
        end else if (w_is_sfd) begin
          w_state_nxt = DATA;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_sop_nxt   = 1'b1;
          w_err_nxt   = 1'b0;
        end
      end
      DATA: begin
        if (!r_dv) begin
          // End of frame: flush whatever is held. An empty flush (zero-byte
          // frame or a lone dribble nibble) is always an error.
          w_req   = 1'b1;
          w_pdata = r_acc;
          w_pkeep = w_keep_part;
          w_psop  = r_sop_pend;
          w_peop  = 1'b1;
          w_perr  = r_err || w_dribble || (r_cnt == '0);
          if (w_space) begin
            w_state_nxt = IDLE;
            w_inc_ok    = !w_perr;
            w_inc_err   = w_perr;
          end else begin
            w_ovf = 1'b1;
          end
        end else begin
          if (r_er) w_err_nxt = 1'b1;
          if (r_cnt == CW'(BYTES)) begin
            w_req   = 1'b1;
            w_pdata = r_acc;
            w_pkeep = '1;
            w_psop  = r_sop_pend;
            if (w_space) begin
              w_sop_nxt = 1'b0;
              w_acc_nxt = '0;
              if (w_byte_done) begin
                w_acc_nxt[7:0] = w_byte;
                w_cnt_nxt      = CW'(1);
              end else begin
                w_cnt_nxt = '0;
              end
            end else begin
              w_ovf = 1'b1;
            end
          end else if (w_byte_done) begin
            w_acc_nxt = w_merge;
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        // Lost word: a frame with no sop delivered yet is simply dropped;
        // otherwise the consumer is owed a terminating abort word.
        if (w_ovf) begin
          w_state_nxt = DROP;
          if (r_sop_pend) w_inc_drop  = 1'b1;
          else            w_abort_nxt = 1'b1;
        end
      end
      DROP: begin
        if (r_abort && w_space) begin
          w_req       = 1'b1;
          w_peop      = 1'b1;
          w_perr      = 1'b1;
          w_abort_nxt = 1'b0;
          w_inc_err   = 1'b1;
        end
        if (!r_dv && !r_abort) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mrx_clk_pad_i or negedge mrx_rst_n_i) begin
    if (!mrx_rst_n_i) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_sop_pend  <= 1'b0;
      r_err       <= 1'b0;
      r_abort     <= 1'b0;
      r_stat_ok   <= '0;
      r_stat_err  <= '0;
      r_stat_drop <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_acc      <= w_acc_nxt;
      r_cnt      <= w_cnt_nxt;
      r_sop_pend <= w_sop_nxt;
      r_err      <= w_err_nxt;
      r_abort    <= w_abort_nxt;
      if (w_inc_ok && (r_stat_ok != {CNT_W{1'b1}}))
        r_stat_ok <= r_stat_ok + CNT_W'(1);
      if (w_inc_err && (r_stat_err != {CNT_W{1'b1}}))
        r_stat_err <= r_stat_err + CNT_W'(1);
      if (w_inc_drop && (r_stat_drop != {CNT_W{1'b1}}))
        r_stat_drop <= r_stat_drop + CNT_W'(1);
    end
  end

  phy_rx_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (mrx_clk_pad_i),
    .rst_n     (mrx_rst_n_i),
    .i_wr_en   (w_push),
    .i_wr_data ({w_pdata, w_pkeep, w_psop, w_peop, w_perr}),
    .i_rd_en   (rx_ready_i),
    .o_rd_data (w_rd_data),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign rx_valid_o = !w_empty;
  assign {rx_data_o, rx_keep_o, rx_sop_o, rx_eop_o, rx_err_o} = w_rd_data;
  assign stat_ok_o   = r_stat_ok;
  assign stat_err_o  = r_stat_err;
  assign stat_drop_o = r_stat_drop;

endmodule : phy_rx_deframer
`default_nettype wire

// File: tb/tb_phy_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module      : tb_phy_rx_deframer
// Description : Self-checking bench for phy_rx_deframer with one MII
//               instance (BYTES=4, DEPTH=4) and one GMII instance (BYTES=4,
//               DEPTH=16). Expected words are queued when a frame is driven
//               and compared as the DUT hands them over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phy_rx_deframer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  // MII instance
  logic [3:0]  m_rxd;
  logic        m_dv, m_er, m_ready;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_sop, m_eop, m_err, m_valid;
  logic [15:0] m_ok, m_errc, m_drop;
  // GMII instance
  logic [7:0]  gm_rxd;
  logic        gm_dv, gm_er, gm_ready;
  logic [31:0] gm_data;
  logic [3:0]  gm_keep;
  logic        gm_sop, gm_eop, gm_err, gm_valid;
  logic [15:0] gm_ok, gm_errc, gm_drop;

  int n_checks = 0;
  int n_errors = 0;
  logic [38:0] q_m[$];
  logic [38:0] q_g[$];

  phy_rx_deframer #(.PHY_W(4), .BYTES(4), .DEPTH(4), .CNT_W(16)) u_mii (
    .mrx_clk_pad_i (clk),     .mrx_rst_n_i  (rst_n),
    .mrxd_pad_i    (m_rxd),   .mrxdv_pad_i  (m_dv),    .mrxerr_pad_i (m_er),
    .rx_data_o     (m_data),  .rx_keep_o    (m_keep),  .rx_sop_o     (m_sop),
    .rx_eop_o      (m_eop),   .rx_err_o     (m_err),   .rx_valid_o   (m_valid),
    .rx_ready_i    (m_ready), .stat_ok_o    (m_ok),    .stat_err_o   (m_errc),
    .stat_drop_o   (m_drop)
  );

  phy_rx_deframer #(.PHY_W(8), .BYTES(4), .DEPTH(16), .CNT_W(16)) u_gmii (
    .mrx_clk_pad_i (clk),      .mrx_rst_n_i  (rst_n),
    .mrxd_pad_i    (gm_rxd),   .mrxdv_pad_i  (gm_dv),   .mrxerr_pad_i (gm_er),
    .rx_data_o     (gm_data),  .rx_keep_o    (gm_keep), .rx_sop_o     (gm_sop),
    .rx_eop_o      (gm_eop),   .rx_err_o     (gm_err),  .rx_valid_o   (gm_valid),
    .rx_ready_i    (gm_ready), .stat_ok_o    (gm_ok),   .stat_err_o   (gm_errc),
    .stat_drop_o   (gm_drop)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [38:0] pack(input logic [31:0] d, input logic [3:0] k,
                                       input logic s, input logic e, input logic r);
    return {d, k, s, e, r};
  endfunction

  // Scoreboard monitors: a word is transferred on the posedge following a
  // negedge that sees valid & ready.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (q_m.size() == 0) check_eq("mii_unexpected_word", 64'(m_data), 64'hFFFF_FFFF_FFFF_FFFF);
      else check_eq("mii_word", 64'({m_data, m_keep, m_sop, m_eop, m_err}), 64'(q_m.pop_front()));
    end
    if (rst_n && gm_valid && gm_ready) begin
      if (q_g.size() == 0) check_eq("gmii_unexpected_word", 64'(gm_data), 64'hFFFF_FFFF_FFFF_FFFF);
      else check_eq("gmii_word", 64'({gm_data, gm_keep, gm_sop, gm_eop, gm_err}), 64'(q_g.pop_front()));
    end
  end

  task automatic exp_frame(input int which, input logic [7:0] pl[$], input bit err);
    int n;
    logic [31:0] d;
    logic [3:0]  k;
    logic        last;
    n = pl.size();
    if (n == 0) begin
      if (which == 0) q_m.push_back(pack(32'h0, 4'h0, 1'b1, 1'b1, 1'b1));
      else            q_g.push_back(pack(32'h0, 4'h0, 1'b1, 1'b1, 1'b1));
    end
    for (int i = 0; i < n; i += 4) begin
      d = '0;
      k = '0;
      for (int b = 0; b < 4; b++) begin
        if (i + b < n) begin
          d[8*b +: 8] = pl[i+b];
          k[b] = 1'b1;
        end
      end
      last = (i + 4 >= n);
      if (which == 0) q_m.push_back(pack(d, k, i == 0, last, last && err));
      else            q_g.push_back(pack(d, k, i == 0, last, last && err));
    end
  endtask

  task automatic mii_unit(input logic [3:0] nib, input logic er);
    m_rxd = nib; m_dv = 1'b1; m_er = er;
    @(posedge clk); #1;
  endtask

  task automatic mii_idle(input int n);
    m_rxd = '0; m_dv = 1'b0; m_er = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic mii_frame(input logic [7:0] pl[$], input int err_byte, input bit dribble);
    repeat (15) mii_unit(4'h5, 1'b0);
    mii_unit(4'hD, 1'b0);
    for (int i = 0; i < pl.size(); i++) begin
      mii_unit(pl[i][3:0], i == err_byte);
      mii_unit(pl[i][7:4], i == err_byte);
    end
    if (dribble) mii_unit(4'h7, 1'b0);
    mii_idle(2);
  endtask

  task automatic gmii_unit(input logic [7:0] b);
    gm_rxd = b; gm_dv = 1'b1; gm_er = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic gmii_frame(input logic [7:0] pl[$], input int ipg);
    repeat (7) gmii_unit(8'h55);
    gmii_unit(8'hD5);
    for (int i = 0; i < pl.size(); i++) gmii_unit(pl[i]);
    gm_rxd = '0; gm_dv = 1'b0;
    repeat (ipg) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain(input int which);
    for (int c = 0; c < 300; c++) begin
      if ((which == 0 ? q_m.size() : q_g.size()) == 0) break;
      @(posedge clk);
    end
    #1;
    check_eq(which == 0 ? "mii_drain" : "gmii_drain",
             64'(which == 0 ? q_m.size() : q_g.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    logic [7:0] pl[$];
    logic [7:0] pl2[$];
    logic [31:0] d;

    rst_n = 1'b0;
    m_rxd = '0; m_dv = 1'b0; m_er = 1'b0; m_ready = 1'b1;
    gm_rxd = '0; gm_dv = 1'b0; gm_er = 1'b0; gm_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_mii_valid", 64'(m_valid), 64'd0);
    check_eq("rst_mii_out", 64'({m_data, m_keep, m_sop, m_eop, m_err}), 64'd0);
    check_eq("rst_mii_stats", 64'({m_ok, m_errc, m_drop}), 64'd0);
    check_eq("rst_gmii_out", 64'({gm_valid, gm_data, gm_keep, gm_sop, gm_eop, gm_err}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // MII 8-byte clean frame
    pl = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    exp_frame(0, pl, 1'b0);
    mii_frame(pl, -1, 1'b0);
    wait_drain(0);
    check_eq("mii_ok_1", 64'(m_ok), 64'd1);

    // GMII 5-byte frame
    pl = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    exp_frame(1, pl, 1'b0);
    gmii_frame(pl, 2);
    wait_drain(1);
    check_eq("gmii_ok_1", 64'(gm_ok), 64'd1);

    // MII receive error on payload byte 3 of 6
    pl = {8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    exp_frame(0, pl, 1'b1);
    mii_frame(pl, 2, 1'b0);
    wait_drain(0);
    check_eq("mii_err_rxerr", 64'(m_errc), 64'd1);

    // MII dribble nibble
    pl = {8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
    exp_frame(0, pl, 1'b1);
    mii_frame(pl, -1, 1'b1);
    wait_drain(0);
    check_eq("mii_err_dribble", 64'(m_errc), 64'd2);

    // MII bad preamble: whole frame dropped, nothing expected
    mii_unit(4'h3, 1'b0);
    repeat (6) mii_unit(4'h5, 1'b0);
    mii_unit(4'hD, 1'b0);
    repeat (8) mii_unit(4'hA, 1'b0);
    mii_idle(10);
    check_eq("mii_drop_cnt", 64'(m_drop), 64'd1);
    check_eq("mii_drop_no_out", 64'(m_valid), 64'd0);
    check_eq("mii_ok_unchanged", 64'(m_ok), 64'd1);

    // GMII zero-byte frame, then exact-multiple frame back-to-back with a
    // 1-cycle gap before a short frame
    pl = {};
    exp_frame(1, pl, 1'b1);
    gmii_frame(pl, 2);
    pl  = {8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    pl2 = {8'h9A, 8'hBC, 8'hDE};
    exp_frame(1, pl, 1'b0);
    exp_frame(1, pl2, 1'b0);
    gmii_frame(pl, 1);
    gmii_frame(pl2, 2);
    wait_drain(1);
    check_eq("gmii_ok_3", 64'(gm_ok), 64'd3);
    check_eq("gmii_err_zero", 64'(gm_errc), 64'd1);
    check_eq("gmii_drop_0", 64'(gm_drop), 64'd0);

    // MII overflow with the consumer stalled: 40-byte frame into DEPTH=4
    m_ready = 1'b0;
    pl = {};
    for (int i = 0; i < 40; i++) pl.push_back(8'(8'h30 + i));
    for (int w = 0; w < 4; w++) begin
      d = {pl[4*w+3], pl[4*w+2], pl[4*w+1], pl[4*w]};
      q_m.push_back(pack(d, 4'hF, w == 0, 1'b0, 1'b0));
    end
    q_m.push_back(pack(32'h0, 4'h0, 1'b0, 1'b1, 1'b1));
    mii_frame(pl, -1, 1'b0);
    mii_idle(5);
    check_eq("ovf_held_valid", 64'(m_valid), 64'd1);
    check_eq("ovf_hold0", 64'({m_data, m_keep, m_sop}), 64'({pl[3], pl[2], pl[1], pl[0], 4'hF, 1'b1}));
    mii_idle(3);
    check_eq("ovf_hold1", 64'({m_data, m_keep, m_sop}), 64'({pl[3], pl[2], pl[1], pl[0], 4'hF, 1'b1}));
    check_eq("ovf_err_pending", 64'(m_errc), 64'd2);
    m_ready = 1'b1;
    wait_drain(0);
    mii_idle(3);
    check_eq("ovf_err_cnt", 64'(m_errc), 64'd3);
    check_eq("ovf_empty_after", 64'(m_valid), 64'd0);

    // Reset in the middle of a payload, then a clean frame
    repeat (15) mii_unit(4'h5, 1'b0);
    mii_unit(4'hD, 1'b0);
    mii_unit(4'h1, 1'b0); mii_unit(4'hC, 1'b0);
    mii_unit(4'h2, 1'b0); mii_unit(4'hC, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out", 64'({m_valid, m_data, m_keep, m_sop, m_eop, m_err}), 64'd0);
    check_eq("midrst_stats", 64'({m_ok, m_errc, m_drop}), 64'd0);
    m_dv = 1'b0; m_rxd = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    pl = {8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC8};
    exp_frame(0, pl, 1'b0);
    mii_frame(pl, -1, 1'b0);
    wait_drain(0);
    check_eq("post_rst_stats", 64'({m_ok, m_errc, m_drop}), 64'({16'd1, 16'd0, 16'd0}));
    check_eq("post_rst_gmii_ok", 64'(gm_ok), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_phy_rx_deframer
`default_nettype wire
